// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry stereo sample buffer feeding a 32-bit frame
// serializer, with the bit clock divided down from clk.
module i2s_tx #(
    parameter int unsigned HALF_DIV = 20
) (
    input  logic        clk,
    input  logic        pll_lock,
    input  logic        en,
    input  logic [15:0] sample_l,
    input  logic [15:0] sample_r,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        hp_bck,
    output logic        hp_ws,
    output logic        hp_din,
    output logic        frame_start,
    output logic        underrun
);

    localparam int unsigned           DIV_W  = $clog2(HALF_DIV);
    localparam logic [DIV_W-1:0]      DIV_TC = DIV_W'(HALF_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic [4:0]       k_next;
    logic [15:0]      pend_l;
    logic [15:0]      pend_r;
    logic             full;
    logic [31:0]      frame;
    logic [31:0]      frame_next;
    logic             div_tc;
    logic             shift_evt;
    logic             frame_evt;
    logic             accept;

    // Handshake: a sample transfers on every clk edge where
    // sample_valid && sample_ready; sample_ready is simply !full and
    // depends neither on sample_valid nor on en.
    assign sample_ready = !full;
    assign accept       = sample_valid && !full;

    // A shift event is the edge on which hp_bck falls.
    assign div_tc    = en && (div_cnt == DIV_TC);
    assign shift_evt = div_tc && hp_bck;
    assign k_next    = bit_cnt + 5'd1;
    assign frame_evt = shift_evt && (k_next == 5'd0);

    always_comb begin
        frame_next = frame;
        if (frame_evt && full) begin
            frame_next = {pend_l, pend_r};
        end
    end

    // Frame load wins over a same-cycle accept: accept only happens when
    // the buffer is empty, in which case the load repeats the old frame.
    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            pend_l <= '0;
            pend_r <= '0;
            full   <= 1'b0;
        end else if (accept) begin
            pend_l <= sample_l;
            pend_r <= sample_r;
            full   <= 1'b1;
        end else if (frame_evt) begin
            full   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            frame <= '0;
        end else begin
            frame <= frame_next;
        end
    end

    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            div_cnt     <= '0;
            bit_cnt     <= 5'd31;
            hp_bck      <= 1'b0;
            hp_ws       <= 1'b0;
            hp_din      <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else if (!en) begin
            div_cnt     <= '0;
            bit_cnt     <= 5'd31;
            hp_bck      <= 1'b0;
            hp_ws       <= 1'b0;
            hp_din      <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= frame_evt;
            underrun    <= frame_evt && !full;
            if (div_tc) begin
                div_cnt <= '0;
                hp_bck  <= ~hp_bck;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            // ws rises on the left LSB so it leads the right MSB by one bit.
            if (shift_evt) begin
                bit_cnt <= k_next;
                hp_ws   <= (k_next >= 5'd15) && (k_next <= 5'd30);
                hp_din  <= frame_next[5'd31 - k_next];
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx (HALF_DIV=2): elapsed-time model of the I2S stream,
// per-cycle output compare, frame capture scoreboard, directed scenarios.
module tb_i2s_tx;

    localparam int HD = 2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        pll_lock = 1'b1;
    logic        en = 1'b0;
    logic [15:0] sample_l = '0;
    logic [15:0] sample_r = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        hp_bck;
    logic        hp_ws;
    logic        hp_din;
    logic        frame_start;
    logic        underrun;

    always #5 clk = ~clk;

    i2s_tx #(.HALF_DIV(HD)) dut (
        .clk          (clk),
        .pll_lock     (pll_lock),
        .en           (en),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .hp_bck       (hp_bck),
        .hp_ws        (hp_ws),
        .hp_din       (hp_din),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    // m_n counts enabled clk edges since enable; every output follows from
    // it by arithmetic: bck half-period = HD clks, one bit = 2*HD clks,
    // frames start on bit 0 of each 32-bit group.
    int          m_n;
    logic        m_full;
    logic [15:0] m_pl;
    logic [15:0] m_pr;
    logic [31:0] m_f;
    logic        m_fs;
    logic        m_ur;
    logic        m_fe;

    assign m_fe = en && (((m_n + 1) % (64 * HD)) == 2 * HD);

    always @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            m_n    <= 0;
            m_full <= 1'b0;
            m_pl   <= '0;
            m_pr   <= '0;
            m_f    <= '0;
            m_fs   <= 1'b0;
            m_ur   <= 1'b0;
        end else begin
            m_n  <= en ? m_n + 1 : 0;
            m_fs <= m_fe;
            m_ur <= m_fe && !m_full;
            if (m_fe && m_full) m_f <= {m_pl, m_pr};
            if (sample_valid && !m_full) begin
                m_pl   <= sample_l;
                m_pr   <= sample_r;
                m_full <= 1'b1;
            end else if (m_fe) begin
                m_full <= 1'b0;
            end
        end
    end

    int         e_s;
    int         e_k;
    logic [4:0] e_kb;
    logic       e_bck;
    logic       e_ws;
    logic       e_din;

    assign e_s   = m_n / (2 * HD);
    assign e_k   = (e_s == 0) ? 31 : (e_s - 1) % 32;
    assign e_kb  = 5'(e_k);
    assign e_bck = ((m_n / HD) % 2) == 1;
    assign e_ws  = (e_k >= 15) && (e_k <= 30);
    assign e_din = (e_s == 0) ? 1'b0 : m_f[5'd31 - e_kb];

    // ---------------- compare + scoreboard ----------------
    logic [31:0] exp_q[$];
    logic        prev_bck = 1'b0;
    logic [31:0] cap_sh = '0;
    int          cap_n = 0;
    bit          cap_on = 1'b0;
    logic [31:0] last_cap = '0;
    int          fs_cnt = 0;
    int          ur_cnt = 0;
    int          acc_cnt = 0;

    always @(negedge clk) begin
        check("sample_ready", 32'(sample_ready), 32'(!m_full));
        check("hp_bck", 32'(hp_bck), 32'(e_bck));
        check("hp_ws", 32'(hp_ws), 32'(e_ws));
        check("hp_din", 32'(hp_din), 32'(e_din));
        check("frame_start", 32'(frame_start), 32'(m_fs));
        check("underrun", 32'(underrun), 32'(m_ur));
        fs_cnt  += int'(frame_start);
        ur_cnt  += int'(underrun);
        acc_cnt += int'(sample_valid && sample_ready);
        if (m_n == 0) begin
            exp_q.delete();
            cap_on = 1'b0;
        end else if (m_fs) begin
            exp_q.push_back(m_f);
            cap_on = 1'b1;
            cap_n  = 0;
        end else if (cap_on && hp_bck && !prev_bck) begin
            cap_sh = {cap_sh[30:0], hp_din};
            cap_n++;
            if (cap_n == 32) begin
                if (exp_q.size() == 0) begin
                    timeout("frame_expected");
                end else begin
                    check("frame_serial", cap_sh, exp_q.pop_front());
                end
                last_cap = cap_sh;
                cap_on   = 1'b0;
            end
        end
        prev_bck = hp_bck;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        bit done;
        done = 1'b0;
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (sample_ready) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) timeout("push");
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_n(input int target);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (m_n == target) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) timeout("wait_n");
    endtask

    task automatic clear_counts();
        fs_cnt  = 0;
        ur_cnt  = 0;
        acc_cnt = 0;
    endtask

    task automatic restart_en();
        en = 1'b0;
        tick();
        tick();
        en = 1'b1;
        clear_counts();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        bit seen;
        #1 pll_lock = 1'b0;
        tick();
        check("rst_ready", 32'(sample_ready), 32'd1);
        check("rst_bck", 32'(hp_bck), 32'd0);
        check("rst_ws", 32'(hp_ws), 32'd0);
        check("rst_din", 32'(hp_din), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_ur", 32'(underrun), 32'd0);
        tick();
        pll_lock = 1'b1;
        tick();

        // First frame A5C3/0F01, then a repeated frame with underrun.
        en = 1'b1;
        clear_counts();
        push(16'hA5C3, 16'h0F01);
        wait_n(61);
        check("ws_k14", 32'(hp_ws), 32'd0);
        check("din_k14", 32'(hp_din), 32'd1);
        wait_n(65);
        check("ws_k15", 32'(hp_ws), 32'd1);
        check("din_k15", 32'(hp_din), 32'd1);
        wait_n(69);
        check("din_k16", 32'(hp_din), 32'd0);
        wait_n(200);
        check("frame1_bits", last_cap, 32'hA5C30F01);
        check("frame1_fs_cnt", 32'(fs_cnt), 32'd2);
        check("frame1_ur_cnt", 32'(ur_cnt), 32'd1);
        wait_n(262);
        check("repeat_bits", last_cap, 32'hA5C30F01);
        check("repeat_ur_cnt", 32'(ur_cnt), 32'd2);

        // Continuous valid: one accept and one frame per 128 clks.
        restart_en();
        sample_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            sample_l = 16'($urandom_range(0, 65535));
            sample_r = 16'($urandom_range(0, 65535));
            if (frame_start) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) timeout("stream_fs");
        for (int w = 0; w < 2; w++) begin
            clear_counts();
            for (int i = 0; i < 128; i++) begin
                tick();
                sample_l = 16'($urandom_range(0, 65535));
                sample_r = 16'($urandom_range(0, 65535));
            end
            check("stream_acc", 32'(acc_cnt), 32'd1);
            check("stream_fs", 32'(fs_cnt), 32'd1);
            check("stream_ur", 32'(ur_cnt), 32'd0);
        end
        sample_valid = 1'b0;

        // Enable dropped at k=10 with a sample pending.
        restart_en();
        wait_n(8);
        push(16'h3C5A, 16'h8001);
        wait_n(45);
        en = 1'b0;
        tick();
        check("abort_bck", 32'(hp_bck), 32'd0);
        check("abort_ws", 32'(hp_ws), 32'd0);
        check("abort_din", 32'(hp_din), 32'd0);
        check("abort_pending", 32'(sample_ready), 32'd0);
        tick();
        en = 1'b1;
        clear_counts();
        repeat (140) tick();
        check("resume_bits", last_cap, 32'h3C5A8001);
        check("resume_ur_cnt", 32'(ur_cnt), 32'd1);

        // pll_lock pulsed low mid-frame with a sample buffered.
        restart_en();
        wait_n(8);
        push(16'h7777, 16'h1111);
        wait_n(20);
        #2 pll_lock = 1'b0;
        #1;
        check("arst_ready", 32'(sample_ready), 32'd1);
        check("arst_bck", 32'(hp_bck), 32'd0);
        check("arst_ws", 32'(hp_ws), 32'd0);
        check("arst_din", 32'(hp_din), 32'd0);
        check("arst_fs_ur", {30'd0, frame_start, underrun}, 32'd0);
        tick();
        en = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();

        // Accept on the exact frame-load cycle with the buffer empty.
        en = 1'b1;
        clear_counts();
        tick();
        tick();
        tick();
        sample_l     = 16'h1234;
        sample_r     = 16'hFEDC;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("late_ur", 32'(underrun), 32'd1);
        check("late_fs", 32'(frame_start), 32'd1);
        check("late_full", 32'(sample_ready), 32'd0);
        repeat (60) tick();
        check("late_full_mid", 32'(sample_ready), 32'd0);
        repeat (70) tick();
        check("late_frame1", last_cap, 32'h00000000);
        repeat (130) tick();
        check("late_frame2", last_cap, 32'h1234FEDC);
        check("late_empty", 32'(sample_ready), 32'd1);

        en = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter HALF_DIV, default 20: clk cycles per half hp_bck period (legal range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: the single system/pixel clock.
REQ-003 SHALL have port pll_lock, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port en, input, 1 bit: transmitter enable.
REQ-005 SHALL have port sample_l, input, 16 bits: signed left sample.
REQ-006 SHALL have port sample_r, input, 16 bits: signed right sample.
REQ-007 SHALL have port sample_valid, input, 1 bit: sample_l and sample_r are valid this cycle.
REQ-008 SHALL have port sample_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-009 SHALL have port hp_bck, output, 1 bit: I2S bit clock.
REQ-010 SHALL have port hp_ws, output, 1 bit: I2S word select (0 = left, 1 = right).
REQ-011 SHALL have port hp_din, output, 1 bit: I2S serial data, MSB first.
REQ-012 SHALL have port frame_start, output, 1 bit: one-clk pulse when a frame begins.
REQ-013 SHALL have port underrun, output, 1 bit: one-clk pulse when a frame starts with no sample pending.

Function
REQ-014 SHALL contain a one-entry pending buffer (pend_l, pend_r, full); sample_ready SHALL equal !full, independent of en.
REQ-015 SHALL accept a sample when sample_valid && sample_ready, writing pend_l/pend_r and setting full on the next edge.
REQ-016 SHALL run div_cnt from 0 to HALF_DIV-1 while en=1; at the terminal count it SHALL wrap to 0 and toggle hp_bck.
REQ-017 SHALL define a shift event as the clk edge on which hp_bck toggles 1->0; all data, word-select and frame events SHALL occur only on shift events.
REQ-018 SHALL keep a 5-bit bit_cnt k that increments (mod 32) on each shift event.
REQ-019 SHALL, at the shift event where k becomes 0, load frame register F = {L,R} (32 bits) from the pending buffer if full=1 and clear full.
REQ-020 SHALL, at the REQ-019 event with full=0, keep F equal to the previous frame and pulse underrun for one cycle.
REQ-021 SHALL pulse frame_start for one cycle at every REQ-019 event.
REQ-022 SHALL give the REQ-019 load precedence over a same-cycle accept: if full=1, buffer contents load into F and full clears; if full=0 with an accept in that cycle, F repeats, underrun pulses, and the new sample lands in the buffer.
REQ-023 SHALL drive hp_din = F[31-k] after each shift event, registered and stable for a full bck period.
REQ-024 SHALL drive hp_ws = 1 for k in 15..30 and 0 for k in 31 and 0..14, so ws leads its word's MSB by one bit (standard I2S).
REQ-025 SHALL, when en=0, hold div_cnt=0, bit_cnt=31, hp_bck=0, hp_ws=0 and hp_din=0, and SHALL keep F and the pending buffer.
REQ-026 SHALL begin after en goes 0->1 with the first shift event (after 2*HALF_DIV clks) at k=0, i.e. a frame load.
REQ-027 SHALL make en falling mid-frame abort the frame immediately, with no further underrun or frame_start pulses.

Reset
REQ-028 SHALL, on pll_lock=0 and asynchronously, clear div_cnt, F, pend_l, pend_r, full, hp_bck, hp_ws, hp_din, frame_start and underrun, and set bit_cnt=31; sample_ready SHALL read 1 during reset.
REQ-029 SHALL resume operation synchronously on the first clk edge after pll_lock rises, as in REQ-026 if en=1.

Verification (HALF_DIV=2)
REQ-030 SHALL cover: reset, en=1, push L=16'hA5C3 R=16'h0F01 -> the first frame's hp_din reads A5C3 then 0F01 MSB-first on bck rising edges, hp_ws=0 during L bits and 1 during R bits, with ws changing one bit before each MSB.
REQ-031 SHALL cover: hold sample_valid=1 continuously -> exactly one accept per 128 clks, frame_start every 128 clks, no underrun.
REQ-032 SHALL cover: push one sample only -> the second frame repeats the same 32 bits and underrun pulses once at its start.
REQ-033 SHALL cover: sample_valid with full=0 on the exact cycle of a frame load -> underrun pulses, the sample is transmitted in the following frame, and full=1 in between.
REQ-034 SHALL cover: en dropped at k=10 -> hp_bck, hp_ws and hp_din go to 0 next cycle; after re-enable the next frame starts at k=0 with the pending sample.
REQ-035 SHALL cover: pll_lock pulsed low mid-frame -> all outputs are 0 immediately (sample_ready=1) and the buffered sample is discarded.
